// File: rtl/nvm_cmd_pkg.sv
// Shared opcode/mode constants, queued-command record and executor state
// encoding for the NVMain command responder.
package nvm_cmd_pkg;

  localparam logic [7:0] OP_PROBE = 8'h49;
  localparam logic [7:0] OP_LOAD  = 8'h4C;
  localparam logic [7:0] OP_COMP  = 8'h43;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;

  localparam logic [7:0] MODE_X = 8'h58;
  localparam logic [7:0] MODE_Y = 8'h59;

  localparam int LAT_W = 21;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] cnt;
    logic [7:0]  mode;
  } nvm_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } exec_state_t;

  // ASCII letters differ from their upper-case form only in bit 5.
  function automatic logic [7:0] norm_op(input logic [7:0] op);
    return op & 8'hDF;
  endfunction

endpackage

// File: rtl/nvm_cmd_fifo.sv
// Synchronous power-of-two FIFO with occupancy count; push ignored when full,
// pop ignored when empty, and both may occur in the same cycle.
module nvm_cmd_fifo #(
  parameter int DATA_W = 112,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nvm_cmd_responder.sv
// NVMain command target: decodes the five-argument command bus, queues
// L/C/R/W commands and drains them through a latency-modelling executor.
module nvm_cmd_responder
  import nvm_cmd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LAT_LOAD  = 8,
  parameter int LAT_COMP  = 16,
  parameter int LAT_READ  = 4,
  parameter int LAT_WRITE = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        command_enable,
  input  logic [7:0]  arg0,
  input  logic [31:0] arg1,
  input  logic [31:0] arg2,
  input  logic [31:0] arg3,
  input  logic [7:0]  arg4,
  output logic        is_issuable,
  output logic        cmd_done,
  output logic [7:0]  done_opcode,
  output logic [31:0] done_addr,
  output logic        err_illegal,
  output logic        err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [7:0]       op_n;
  logic             is_probe;
  logic             is_valid;
  logic             push;
  logic             pop;
  nvm_cmd_t         din;
  nvm_cmd_t         head;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  exec_state_t      state;
  logic [LAT_W-1:0] cnt;
  logic [7:0]       cur_op;
  logic [31:0]      cur_addr;
  logic             unused_bits;

  // Executor cycles minus one; a 'Y' compute adds the low nibble of the count field.
  function automatic logic [LAT_W-1:0] lat_minus1(input nvm_cmd_t c);
    logic [LAT_W-1:0] lat;
    case (c.op)
      OP_LOAD:  lat = LAT_W'(LAT_LOAD);
      OP_COMP:  lat = (c.mode == MODE_Y) ? LAT_W'(LAT_COMP) + LAT_W'(c.cnt[3:0])
                                         : LAT_W'(LAT_COMP);
      OP_READ:  lat = LAT_W'(LAT_READ);
      default:  lat = LAT_W'(LAT_WRITE);
    endcase
    return lat - LAT_W'(1);
  endfunction

  always_comb begin
    op_n     = norm_op(arg0);
    is_probe = (op_n == OP_PROBE);
    is_valid = (op_n == OP_LOAD) || (op_n == OP_READ) || (op_n == OP_WRITE) ||
               ((op_n == OP_COMP) && ((arg4 == MODE_X) || (arg4 == MODE_Y)));
  end

  assign din         = '{op: op_n, addr: arg1, len: arg2, cnt: arg3, mode: arg4};
  assign push        = command_enable && is_valid && !full;
  assign pop         = !empty && (state != ST_BUSY);
  assign is_issuable = (count != CNT_FULL);
  assign unused_bits = ^{head.len, head.cnt[31:4]};

  nvm_cmd_fifo #(
    .DATA_W ($bits(nvm_cmd_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Decode stage -> registered error pulses; full is judged before any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_illegal  <= command_enable && !is_probe && !is_valid;
      err_overflow <= command_enable && is_valid && full;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      cur_op   <= head.op;
      cur_addr <= head.addr;
    end
  end

  // Executor: pop -> count down latency -> one-cycle completion report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cmd_done    <= 1'b0;
      done_opcode <= '0;
      done_addr   <= '0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            cnt   <= lat_minus1(head);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state       <= ST_DONE;
            cmd_done    <= 1'b1;
            done_opcode <= cur_op;
            done_addr   <= cur_addr;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (!empty) begin
            cnt   <= lat_minus1(head);
            state <= ST_BUSY;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_cmd_responder.sv
// Directed bench for nvm_cmd_responder: single-command vector table plus
// back-to-back, overflow and mid-execution reset sequences.
module tb_nvm_cmd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        command_enable = 1'b0;
  logic [7:0]  arg0 = '0;
  logic [31:0] arg1 = '0;
  logic [31:0] arg2 = '0;
  logic [31:0] arg3 = '0;
  logic [7:0]  arg4 = '0;
  logic        is_issuable;
  logic        cmd_done;
  logic [7:0]  done_opcode;
  logic [31:0] done_addr;
  logic        err_illegal;
  logic        err_overflow;

  nvm_cmd_responder dut (
    .clk            (clk),
    .rst            (rst),
    .command_enable (command_enable),
    .arg0           (arg0),
    .arg1           (arg1),
    .arg2           (arg2),
    .arg3           (arg3),
    .arg4           (arg4),
    .is_issuable    (is_issuable),
    .cmd_done       (cmd_done),
    .done_opcode    (done_opcode),
    .done_addr      (done_addr),
    .err_illegal    (err_illegal),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  int          done_q[$];
  logic [7:0]  dop_q[$];
  logic [31:0] dad_q[$];
  int          ill_cnt = 0;
  int          ovf_cnt = 0;

  always @(negedge clk) begin
    if (cmd_done) begin
      done_q.push_back(cyc);
      dop_q.push_back(done_opcode);
      dad_q.push_back(done_addr);
    end
    if (err_illegal)  ill_cnt++;
    if (err_overflow) ovf_cnt++;
  end

  typedef struct {
    logic [7:0]  a0;
    logic [31:0] a1;
    logic [31:0] a3;
    logic [7:0]  a4;
    int          exp_done;
    int          exp_lat;
    logic [7:0]  exp_op;
    int          exp_ill;
    string       name;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a0, input logic [31:0] a1, input logic [31:0] a3,
                       input logic [7:0] a4, output int acc);
    @(negedge clk);
    command_enable = 1'b1;
    arg0 = a0;
    arg1 = a1;
    arg2 = 32'h40;
    arg3 = a3;
    arg4 = a4;
    acc  = cyc + 1;
  endtask

  task automatic idle();
    @(negedge clk);
    command_enable = 1'b0;
  endtask

  initial begin
    int acc, acc1, acc2, n0, i0, o0, bad;
    logic iss[6];
    logic exp_iss[6];

    vt[0]  = '{8'h4C, 32'h00010000, 32'h0,        8'h00, 1, 9,  8'h4C, 0, "load"};
    vt[1]  = '{8'h72, 32'h00040000, 32'h0,        8'h00, 1, 5,  8'h52, 0, "read_lc"};
    vt[2]  = '{8'h57, 32'h00000100, 32'h0,        8'h00, 1, 7,  8'h57, 0, "write"};
    vt[3]  = '{8'h77, 32'h00000200, 32'h0,        8'h00, 1, 7,  8'h57, 0, "write_lc"};
    vt[4]  = '{8'h43, 32'h00000300, 32'h00010000, 8'h58, 1, 17, 8'h43, 0, "comp_x"};
    vt[5]  = '{8'h63, 32'h00000400, 32'h0000000F, 8'h59, 1, 32, 8'h43, 0, "comp_y_f"};
    vt[6]  = '{8'h6C, 32'hDEADBEEF, 32'h0,        8'h00, 1, 9,  8'h4C, 0, "load_lc"};
    vt[7]  = '{8'h69, 32'h00000500, 32'h0,        8'h00, 0, 0,  8'h00, 0, "probe_lc"};
    vt[8]  = '{8'h49, 32'h00000600, 32'h0,        8'h00, 0, 0,  8'h00, 0, "probe"};
    vt[9]  = '{8'h7A, 32'h00000700, 32'h0,        8'h00, 0, 0,  8'h00, 1, "bad_op"};
    vt[10] = '{8'h43, 32'h00000800, 32'h0,        8'h5A, 0, 0,  8'h00, 1, "bad_mode"};

    // Reset state and quiet idle period
    repeat (3) @(negedge clk);
    chk("rst_issuable", {31'b0, is_issuable}, 32'd1);
    chk("rst_done_op", {24'b0, done_opcode}, 32'h0);
    chk("rst_done_addr", done_addr, 32'h0);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_issuable !== 1'b1 || cmd_done !== 1'b0 || err_illegal !== 1'b0 ||
          err_overflow !== 1'b0) bad++;
    end
    chk("idle_20_cycles_bad", bad, 32'd0);

    // Single-command vectors
    for (int v = 0; v < 11; v++) begin
      n0 = done_q.size();
      i0 = ill_cnt;
      o0 = ovf_cnt;
      issue(vt[v].a0, vt[v].a1, vt[v].a3, vt[v].a4, acc);
      idle();
      repeat (40) @(negedge clk);
      chk({vt[v].name, "_done_cnt"}, done_q.size() - n0, vt[v].exp_done);
      chk({vt[v].name, "_ill_cnt"}, ill_cnt - i0, vt[v].exp_ill);
      chk({vt[v].name, "_ovf_cnt"}, ovf_cnt - o0, 32'd0);
      if (vt[v].exp_done == 1 && done_q.size() > n0) begin
        chk({vt[v].name, "_latency"}, done_q[n0] - acc, vt[v].exp_lat);
        chk({vt[v].name, "_op"}, {24'b0, dop_q[n0]}, {24'b0, vt[v].exp_op});
        chk({vt[v].name, "_addr"}, dad_q[n0], vt[v].a1);
      end
    end

    // Back-to-back compute X then Y
    n0 = done_q.size();
    issue(8'h43, 32'h00001000, 32'h00010000, 8'h58, acc1);
    issue(8'h43, 32'h00002000, 32'h00000005, 8'h59, acc2);
    idle();
    repeat (60) @(negedge clk);
    chk("cxy_done_cnt", done_q.size() - n0, 32'd2);
    if (done_q.size() >= n0 + 2) begin
      chk("cxy_first_lat", done_q[n0] - acc1, 32'd17);
      chk("cxy_gap", done_q[n0+1] - done_q[n0], 32'd22);
      chk("cxy_second_addr", dad_q[n0+1], 32'h00002000);
    end

    // Six writes on consecutive cycles: one overflow
    n0 = done_q.size();
    o0 = ovf_cnt;
    exp_iss = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      issue(8'h57, 32'h00003000 + k, 32'h0, 8'h00, acc);
      @(posedge clk);
      #1 iss[k] = is_issuable;
    end
    idle();
    for (int k = 0; k < 6; k++) chk($sformatf("w6_issuable_%0d", k), {31'b0, iss[k]}, {31'b0, exp_iss[k]});
    repeat (60) @(negedge clk);
    chk("w6_ovf_cnt", ovf_cnt - o0, 32'd1);
    chk("w6_done_cnt", done_q.size() - n0, 32'd5);
    if (done_q.size() >= n0 + 5) begin
      chk("w6_gap", done_q[n0+1] - done_q[n0], 32'd7);
      chk("w6_last_addr", dad_q[n0+4], 32'h00003004);
    end

    // Reset while busy with a full queue
    for (int k = 0; k < 5; k++) issue(8'h4C, 32'h00005000 + k, 32'h0, 8'h00, acc);
    idle();
    chk("rb_full_issuable", {31'b0, is_issuable}, 32'd0);
    n0 = done_q.size();
    #2 rst = 1'b1;
    #1;
    chk("rb_rst_issuable", {31'b0, is_issuable}, 32'd1);
    chk("rb_rst_done_op", {24'b0, done_opcode}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rb_no_done", done_q.size() - n0, 32'd0);
    chk("rb_after_issuable", {31'b0, is_issuable}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
